// File: rtl/bist_pkg.sv
// Shared BIST definitions: MISR state encoding and the default
// polynomial / seed / golden constants used by the pattern generator,
// the compactor and the BIST top level.
package bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPACT = 2'd1,
    ST_COMPARE = 2'd2,
    ST_DONE    = 2'd3
  } misr_state_t;

  // x^8 + x^4 + x^3 + x^2 + 1, implicit x^8 term omitted
  localparam logic [7:0] DEF_POLY   = 8'h1D;
  localparam logic [7:0] DEF_SEED   = 8'h00;
  localparam logic [7:0] DEF_GOLDEN = 8'h00;

endpackage

// File: rtl/misr_core.sv
// Signature register with Galois (shift toward MSB) MISR update.
// Ports:
//   clk, rst - clock and synchronous active-high reset (sig <= SEED)
//   load     - load seed into the register (takes priority over en)
//   seed     - value loaded on load
//   en       - absorb din into the signature this cycle
//   din      - response vector
//   sig      - current signature
module misr_core
  import bist_pkg::*;
#(
  parameter int unsigned    W    = 8,
  parameter logic [W-1:0]   POLY = W'(DEF_POLY),
  parameter logic [W-1:0]   SEED = W'(DEF_SEED)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] seed,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] sig
);

  logic [W-1:0] sig_q;
  logic [W-1:0] sig_d;

  always_comb begin
    sig_d = sig_q;
    if (load) begin
      sig_d = seed;
    end else if (en) begin
      sig_d = {sig_q[W-2:0], 1'b0} ^ (sig_q[W-1] ? POLY : '0) ^ din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/bist_misr_compactor.sv
// MISR response compactor: compacts one response per accepted cycle into a
// W-bit signature, compares it with GOLDEN, and reports pass/fail/done.
// A vector-count watchdog aborts a session lacking a `last` vector.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   start      - begin a session (honoured in IDLE or DONE only)
//   resp_valid - resp valid this cycle (used in COMPACT only)
//   resp       - CUT response vector
//   last       - marks the final vector (qualified by resp_valid)
//   busy       - high in COMPACT and COMPARE
//   done       - high in DONE
//   pass       - signature matched GOLDEN (valid while done)
//   timeout    - watchdog abort (valid while done)
//   signature  - current signature register
module bist_misr_compactor
  import bist_pkg::*;
#(
  parameter int unsigned  W       = 8,
  parameter logic [W-1:0] POLY    = W'(DEF_POLY),
  parameter logic [W-1:0] SEED    = W'(DEF_SEED),
  parameter logic [W-1:0] GOLDEN  = W'(DEF_GOLDEN),
  parameter int unsigned  MAX_VEC = 1000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         resp_valid,
  input  logic [W-1:0] resp,
  input  logic         last,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic         timeout,
  output logic [W-1:0] signature
);

  localparam int unsigned    CW    = $clog2(MAX_VEC + 1);
  localparam logic [CW-1:0]  LIMIT = CW'(MAX_VEC - 1);

  misr_state_t   state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          pass_q, pass_d;
  logic          timeout_q, timeout_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          load, en;
  logic [W-1:0]  sig;

  misr_core #(
    .W    (W),
    .POLY (POLY),
    .SEED (SEED)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .seed (SEED),
    .en   (en),
    .din  (resp),
    .sig  (sig)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    pass_d    = pass_q;
    timeout_d = timeout_q;
    load      = 1'b0;
    en        = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_COMPACT;
          load      = 1'b1;
          count_d   = '0;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
        end
      end
      ST_COMPACT: begin
        if (resp_valid) begin
          en      = 1'b1;
          count_d = count_q + CW'(1);
          if (last) begin
            state_d = ST_COMPARE;
          end else if (count_q == LIMIT) begin
            // Limit reached without `last`: abort straight to DONE
            state_d   = ST_DONE;
            timeout_d = 1'b1;
            pass_d    = 1'b0;
          end
        end
      end
      ST_COMPARE: begin
        pass_d    = (sig == GOLDEN);
        timeout_d = 1'b0;
        state_d   = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Status flags registered from the next state so they align with it
    busy_d = (state_d == ST_COMPACT) || (state_d == ST_COMPARE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign timeout   = timeout_q;
  assign signature = sig;

endmodule

// File: tb/tb_bist_misr_compactor.sv
// Bench for bist_misr_compactor: three instances share stimulus --
// default parameters, GOLDEN=0x1D, and MAX_VEC=4 (watchdog).
module tb_bist_misr_compactor;

  logic       clk = 1'b0;
  logic       rst, start, resp_valid, last;
  logic [7:0] resp;

  logic       d_busy, d_done, d_pass, d_to;
  logic [7:0] d_sig;
  logic       g_busy, g_done, g_pass, g_to;
  logic [7:0] g_sig;
  logic       w_busy, w_done, w_pass, w_to;
  logic [7:0] w_sig;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bist_misr_compactor dut_d (
    .clk(clk), .rst(rst), .start(start), .resp_valid(resp_valid),
    .resp(resp), .last(last), .busy(d_busy), .done(d_done),
    .pass(d_pass), .timeout(d_to), .signature(d_sig)
  );

  bist_misr_compactor #(.GOLDEN(8'h1D)) dut_g (
    .clk(clk), .rst(rst), .start(start), .resp_valid(resp_valid),
    .resp(resp), .last(last), .busy(g_busy), .done(g_done),
    .pass(g_pass), .timeout(g_to), .signature(g_sig)
  );

  bist_misr_compactor #(.MAX_VEC(4)) dut_w (
    .clk(clk), .rst(rst), .start(start), .resp_valid(resp_valid),
    .resp(resp), .last(last), .busy(w_busy), .done(w_done),
    .pass(w_pass), .timeout(w_to), .signature(w_sig)
  );

  typedef struct {
    logic       start;
    logic       rv;
    logic       last;
    logic [7:0] resp;
    logic [7:0] sig;     // expected signature (dut_d and dut_g)
    logic       busy;
    logic       done;
    logic       pass_g;  // expected pass of dut_g
    logic [7:0] w_sig;
    logic       w_done;
    logic       w_to;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic v, input logic l, input logic [7:0] r);
    start = s; resp_valid = v; last = l; resp = r;
  endtask

  initial begin
    //            start rv last resp   sig    busy done pg  w_sig  wd  wto
    vt[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 1'b1, 1'b0, 8'h01, 8'h01, 1'b1, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 1'b0, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h02, 1'b1, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h04, 1'b1, 1'b0, 1'b0, 8'h04, 1'b0, 1'b0};
    vt[5]  = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h08, 1'b1, 1'b0, 1'b0, 8'h08, 1'b1, 1'b1};
    vt[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h10, 1'b1, 1'b0, 1'b0, 8'h08, 1'b1, 1'b1};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h10, 1'b1, 1'b0, 1'b0, 8'h08, 1'b1, 1'b1};
    vt[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h20, 1'b1, 1'b0, 1'b0, 8'h08, 1'b1, 1'b1};
    vt[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h40, 1'b1, 1'b0, 1'b0, 8'h08, 1'b1, 1'b1};
    vt[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h80, 1'b1, 1'b0, 1'b0, 8'h08, 1'b1, 1'b1};
    vt[11] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h80, 1'b1, 1'b0, 1'b0, 8'h08, 1'b1, 1'b1};
    vt[12] = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h1D, 1'b1, 1'b0, 1'b0, 8'h08, 1'b1, 1'b1};
    vt[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h1D, 1'b0, 1'b1, 1'b1, 8'h08, 1'b1, 1'b1};
    vt[14] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h1D, 1'b0, 1'b1, 1'b1, 8'h08, 1'b1, 1'b1};
    vt[15] = '{1'b0, 1'b1, 1'b0, 8'h55, 8'h1D, 1'b0, 1'b1, 1'b1, 8'h08, 1'b1, 1'b1};

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    tick();
    rst = 1'b0;

    // Reset values, held with no start
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_sig", d_sig, 8'h00);
      chk("rst_busy", d_busy, 1'b0);
      chk("rst_done", d_done, 1'b0);
      chk("rst_pass", d_pass, 1'b0);
      chk("rst_timeout", d_to, 1'b0);
    end

    // Main session: gaps, ignored start mid-COMPACT, last without valid,
    // ignored resp_valid in DONE; dut_w aborts on its 4th vector
    for (int i = 0; i < 16; i++) begin
      drive(vt[i].start, vt[i].rv, vt[i].last, vt[i].resp);
      tick();
      chk($sformatf("d_sig[%0d]", i), d_sig, vt[i].sig);
      chk($sformatf("d_busy[%0d]", i), d_busy, vt[i].busy);
      chk($sformatf("d_done[%0d]", i), d_done, vt[i].done);
      chk($sformatf("d_pass[%0d]", i), d_pass, 1'b0);
      chk($sformatf("d_to[%0d]", i), d_to, 1'b0);
      chk($sformatf("g_sig[%0d]", i), g_sig, vt[i].sig);
      chk($sformatf("g_done[%0d]", i), g_done, vt[i].done);
      chk($sformatf("g_pass[%0d]", i), g_pass, vt[i].pass_g);
      chk($sformatf("w_sig[%0d]", i), w_sig, vt[i].w_sig);
      chk($sformatf("w_done[%0d]", i), w_done, vt[i].w_done);
      chk($sformatf("w_to[%0d]", i), w_to, vt[i].w_to);
      chk($sformatf("w_pass[%0d]", i), w_pass, 1'b0);
      chk($sformatf("w_busy[%0d]", i), w_busy, !vt[i].w_done);
    end

    // Start from DONE clears pass/timeout and reloads SEED
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    chk("restart_sig", d_sig, 8'h00);
    chk("restart_busy", d_busy, 1'b1);
    chk("restart_done", d_done, 1'b0);
    chk("restart_g_pass", g_pass, 1'b0);
    chk("restart_w_to", w_to, 1'b0);
    chk("restart_w_busy", w_busy, 1'b1);

    // Three vectors, then reset mid-session
    drive(1'b0, 1'b1, 1'b0, 8'hAA);
    tick();
    drive(1'b0, 1'b1, 1'b0, 8'h55);
    tick();
    drive(1'b0, 1'b1, 1'b0, 8'h0F);
    tick();
    chk("pre_rst_sig", d_sig, 8'h37);
    chk("pre_rst_busy", d_busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_sig", d_sig, 8'h00);
    chk("midrst_busy", d_busy, 1'b0);
    chk("midrst_done", d_done, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("post_rst_sig", d_sig, 8'h00);
      chk("post_rst_busy", d_busy, 1'b0);
    end

    // start and rst on the same edge: reset wins
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    chk("rst_vs_start_busy", d_busy, 1'b0);
    chk("rst_vs_start_done", d_done, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
